// File: rtl/pbs_input_capture_if.sv
// pbs_input_capture_if: board key/switch inputs and the move handshake toward the control FSM
interface pbs_input_capture_if;
    logic [1:0] key_n;
    logic [1:0] sw_move;
    logic       move_valid;
    logic [1:0] move_sel;
    logic       move_ack;
    logic       go_pulse;
    logic       dropped;
    modport master (
        input  key_n, sw_move, move_ack,
        output move_valid, move_sel, go_pulse, dropped
    );
    modport slave (
        output key_n, sw_move, move_ack,
        input  move_valid, move_sel, go_pulse, dropped
    );
endinterface

// File: rtl/pbs_input_capture.sv
// pbs_input_capture: synchronizes and debounces board keys, issues go pulses and a move handshake
module pbs_input_capture #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input logic                 clk,
    input logic                 reset_n,
    pbs_input_capture_if.master bus
);
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_cycles
        $error("DEBOUNCE_CYCLES must lie in 2..65535");
    end
    if (CNT_W < 31 && DEBOUNCE_CYCLES >= (1 << CNT_W)) begin : g_bad_width
        $error("CNT_W too narrow for DEBOUNCE_CYCLES");
    end

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {EMPTY, PENDING} state_t;

    logic [1:0]       key_s1, key_s2;
    logic [1:0]       sw_s1, sw_s2;
    logic [1:0]       stb;
    logic [CNT_W-1:0] cnt [2];
    logic [1:0]       press;
    state_t           state;
    logic [1:0]       sel;
    logic             go;
    logic             drop;

    // two-flop synchronizers; keys idle released (1), switches idle 0
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            key_s1 <= 2'b11;
            key_s2 <= 2'b11;
            sw_s1  <= 2'b00;
            sw_s2  <= 2'b00;
        end else begin
            key_s1 <= bus.key_n;
            key_s2 <= key_s1;
            sw_s1  <= bus.sw_move;
            sw_s2  <= sw_s1;
        end

    // per-key debounce: flip after DEBOUNCE_CYCLES consecutive differing samples; strobe on press
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            stb   <= 2'b11;
            press <= 2'b00;
            for (int k = 0; k < 2; k++) cnt[k] <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                press[k] <= 1'b0;
                if (key_s2[k] == stb[k])
                    cnt[k] <= '0;
                else if (cnt[k] == LAST) begin
                    stb[k]   <= key_s2[k];
                    cnt[k]   <= '0;
                    press[k] <= stb[k];
                end else
                    cnt[k] <= cnt[k] + CNT_W'(1);
            end
        end

    // move handshake FSM plus registered go and overrun pulses
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state <= EMPTY;
            sel   <= 2'b00;
            go    <= 1'b0;
            drop  <= 1'b0;
        end else begin
            go   <= press[1];
            drop <= press[0] && state == PENDING && !bus.move_ack;
            if (press[0] && (state == EMPTY || bus.move_ack)) begin
                state <= PENDING;
                sel   <= sw_s2;
            end else if (bus.move_ack)
                state <= EMPTY;
        end

    assign bus.move_valid = state == PENDING;
    assign bus.move_sel   = sel;
    assign bus.go_pulse   = go;
    assign bus.dropped    = drop;
endmodule
